// File: rtl/decimal_keypad_pkg.sv
// Shared types and helpers for the decimal keypad controller.
package decimal_keypad_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StCapture,
        StRelease
    } state_e;

    typedef logic [3:0] bcd_t;

    function automatic logic is_onehot10(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

endpackage

// File: rtl/decimal_bcd_enc.sv
// One-hot key pattern to BCD digit. Only meaningful for one-hot inputs.
module decimal_bcd_enc
    import decimal_keypad_pkg::*;
(
    input  logic [9:0] key_i,
    output bcd_t       bcd_o
);

    always_comb begin
        bcd_o = '0;
        for (int i = 0; i < 10; i++) begin
            if (key_i[i]) begin
                bcd_o = bcd_t'(i);
            end
        end
    end

endmodule

// File: rtl/decimal_keypad_ctrl.sv
// Debounced 10-key decimal keypad front end feeding a small BCD digit FIFO.
module decimal_keypad_ctrl
    import decimal_keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [9:0]                    key,
    output logic [3:0]                    dig_bcd,
    output logic                          dig_valid,
    input  logic                          dig_ready,
    output logic                          err_multi,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CountW = PtrW + 1;

    state_e            state_q, state_d;
    logic [9:0]        pat_q, pat_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              capture;

    bcd_t              mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0] count_q, count_d;
    logic              err_q, ovf_q;

    logic              push_req, push, pop;
    bcd_t              enc_bcd;

    decimal_bcd_enc u_enc (
        .key_i (pat_q),
        .bcd_o (enc_bcd)
    );

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (key != 10'd0) begin
                    pat_d   = key;
                    cnt_d   = CntW'(1);
                    state_d = StDebounce;
                end
            end
            StDebounce: begin
                if (key == 10'd0) begin
                    pat_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (key != pat_q) begin
                    pat_d = key;
                    cnt_d = CntW'(1);
                end else if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCapture: begin
                capture = 1'b1;
                cnt_d   = '0;
                state_d = StRelease;
            end
            StRelease: begin
                // Leave on the cycle the zero run reaches DEBOUNCE_CYCLES.
                if (key != 10'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    pat_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        push_req = capture && is_onehot10(pat_q);
        pop      = (count_q != '0) && dig_ready;
        push     = push_req && ((count_q < CountW'(FIFO_DEPTH)) || pop);
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CountW'(1);
            2'b01:   count_d = count_q - CountW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pat_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            err_q   <= capture && !is_onehot10(pat_q);
            ovf_q   <= push_req && !push;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= enc_bcd;
        end
    end

    assign dig_valid  = (count_q != '0);
    assign dig_bcd    = dig_valid ? mem_q[rd_ptr_q] : 4'd0;
    assign err_multi  = err_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_decimal_keypad_ctrl.sv
// Randomized and directed bench for decimal_keypad_ctrl against a run-length reference model.
module tb_decimal_keypad_ctrl;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] key = '0;
    logic       dig_ready = 1'b0;
    logic [3:0] dig_bcd;
    logic       dig_valid, err_multi, overflow;
    logic [2:0] fifo_count;

    decimal_keypad_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .dig_bcd    (dig_bcd),
        .dig_valid  (dig_valid),
        .dig_ready  (dig_ready),
        .err_multi  (err_multi),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: press = D+1 identical non-zero samples; the next edge emits the result;
    // afterwards D consecutive zero samples re-arm the detector.
    int         q[$];
    logic [9:0] m_last = '0;
    logic [9:0] m_cap  = '0;
    int         m_run = 0, m_zrun = 0;
    bit         m_rel = 0, m_emit = 0;
    bit         exp_err = 0, exp_ovf = 0;
    int         ovf_seen = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_edge();
        exp_err = 0;
        exp_ovf = 0;
        if (rst) begin
            q.delete();
            m_run = 0; m_zrun = 0; m_last = '0; m_rel = 0; m_emit = 0;
            return;
        end
        if (q.size() > 0 && dig_ready) void'(q.pop_front());
        if (m_emit) begin
            if ($countones(m_cap) == 1) begin
                if (q.size() < DEPTH) q.push_back($clog2(m_cap));
                else exp_ovf = 1;
            end else begin
                exp_err = 1;
            end
            m_emit = 0; m_rel = 1; m_zrun = 0;
        end else if (m_rel) begin
            if (key == 0) m_zrun++;
            else m_zrun = 0;
            if (m_zrun == D) begin
                m_rel = 0; m_run = 0;
            end
        end else begin
            if (key == 0) m_run = 0;
            else if (key == m_last && m_run > 0) m_run++;
            else m_run = 1;
            m_last = key;
            if (m_run == D + 1) begin
                m_emit = 1; m_cap = key;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("dig_valid", int'(dig_valid), int'(q.size() > 0));
        check_eq("dig_bcd", int'(dig_bcd), (q.size() > 0) ? q[0] : 0);
        check_eq("fifo_count", int'(fifo_count), q.size());
        check_eq("err_multi", int'(err_multi), int'(exp_err));
        check_eq("overflow", int'(overflow), int'(exp_ovf));
        if (overflow) ovf_seen++;
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic press(input logic [9:0] pat, input int hold, input int rel);
        key = pat;
        cyc(hold);
        key = '0;
        cyc(rel);
    endtask

    initial begin
        int first;
        int ovf_before;
        logic [9:0] pat;

        cyc(2);
        rst = 1'b0;
        cyc(1);

        // Single press of digit 3, latency and single-digit check.
        first = 0;
        key = 10'b0000001000;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (dig_valid && first == 0) first = i;
        end
        check_eq("s1_latency", first - 1, D + 1);
        check_eq("s1_digit", int'(dig_bcd), 3);
        key = '0;
        cyc(D + 2);
        dig_ready = 1'b1;
        cyc(2);
        dig_ready = 1'b0;

        // Bounce, then stable digit 5.
        for (int i = 0; i < 6; i++) begin
            key = (i % 2 == 0) ? 10'b0000100000 : 10'b0;
            step();
        end
        press(10'b0000100000, 10, D + 2);
        check_eq("s2_digit", int'(dig_bcd), 5);
        dig_ready = 1'b1;
        cyc(2);
        dig_ready = 1'b0;

        // Multi-key press.
        press(10'b0000100001, 10, D + 2);
        check_eq("s3_count", int'(fifo_count), 0);

        // Fill and overflow, then drain in order.
        ovf_before = ovf_seen;
        press(10'b1000000000, D + 3, D + 2);
        press(10'b0000000010, D + 3, D + 2);
        press(10'b0010000000, D + 3, D + 2);
        press(10'b0000000001, D + 3, D + 2);
        press(10'b0000010000, D + 3, D + 2);
        check_eq("s4_ovf_pulses", ovf_seen - ovf_before, 1);
        dig_ready = 1'b1;
        cyc(6);
        dig_ready = 1'b0;

        // Full FIFO with a pop in the push cycle.
        press(10'b0000000100, D + 3, D + 2);
        press(10'b0000001000, D + 3, D + 2);
        press(10'b0000010000, D + 3, D + 2);
        press(10'b0000100000, D + 3, D + 2);
        ovf_before = ovf_seen;
        key = 10'b0001000000;
        cyc(D + 1);
        dig_ready = 1'b1;
        step();
        dig_ready = 1'b0;
        check_eq("s5_no_ovf", ovf_seen - ovf_before, 0);
        check_eq("s5_count", int'(fifo_count), DEPTH);
        key = '0;
        cyc(D + 2);
        dig_ready = 1'b1;
        cyc(6);
        dig_ready = 1'b0;

        // Reset mid-debounce with two digits queued.
        press(10'b0000000010, D + 3, D + 2);
        press(10'b0000000100, D + 3, D + 2);
        key = 10'b0100000000;
        cyc(2);
        rst = 1'b1;
        step();
        check_eq("s6_rst_count", int'(fifo_count), 0);
        rst = 1'b0;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (dig_valid && first == 0) first = i;
        end
        check_eq("s6_latency", first - 1, D + 1);
        key = '0;
        cyc(D + 2);

        // Randomized presses, bounces, consumer stalls and occasional reset.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                pat = 10'($urandom_range(1, 1023));
            end else begin
                pat = 10'b1 << $urandom_range(0, 9);
            end
            for (int c = 0; c < $urandom_range(1, 2 * D + 2); c++) begin
                if ($urandom_range(0, 9) == 0) key = '0;
                else if ($urandom_range(0, 14) == 0) key = 10'b1 << $urandom_range(0, 9);
                else key = pat;
                dig_ready = ($urandom_range(0, 2) == 0);
                rst = ($urandom_range(0, 199) == 0);
                step();
            end
            rst = 1'b0;
            key = '0;
            for (int c = 0; c < $urandom_range(0, D + 3); c++) begin
                if ($urandom_range(0, 7) == 0) key = pat;
                else key = '0;
                dig_ready = ($urandom_range(0, 2) == 0);
                step();
            end
        end
        key = '0;
        dig_ready = 1'b1;
        cyc(D + 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
